// File: rtl/button_repeater.sv
// Turns debounced button levels into one-cycle action pulses, with optional
// auto-repeat (initial delay, then fixed interval) timed by a shared prescaler.
module button_repeater #(
    parameter int              NB           = 5,
    parameter int              PRESCALE     = 100000,
    parameter int              DELAY_TICKS  = 500,
    parameter int              REPEAT_TICKS = 150,
    parameter logic [NB-1:0]   REPEAT_MASK  = 5'b01111
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NB-1:0] I,
    output logic [NB-1:0] P,
    output logic [NB-1:0] H
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX_T = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(DELAY_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick;

    // Free-running prescaler shared by every button; button activity never restarts it.
    assign tick = (presc_q == PS_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    genvar b;
    generate
        for (b = 0; b < NB; b++) begin : g_btn
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
            logic             p_q, p_d;
            logic             h_q, h_d;

            assign cnt_inc = cnt_q + CNT_W'(1);

            // Release is tested first so it wins over a coincident tick or terminal count.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                p_d     = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (I[b]) begin
                            p_d     = 1'b1;
                            cnt_d   = '0;
                            state_d = WAIT;
                        end
                    end
                    WAIT: begin
                        if (!I[b]) begin
                            state_d = IDLE;
                        end else if (tick && (cnt_q != DELAY_C)) begin
                            if ((cnt_inc == DELAY_C) && REPEAT_MASK[b]) begin
                                p_d     = 1'b1;
                                cnt_d   = '0;
                                state_d = REPEAT;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!I[b]) begin
                            state_d = IDLE;
                        end else if (tick) begin
                            if (cnt_inc == REPEAT_C) begin
                                p_d   = 1'b1;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
                h_d = (state_d != IDLE);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    p_q     <= 1'b0;
                    h_q     <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    p_q     <= p_d;
                    h_q     <= h_d;
                end
            end

            assign P[b] = p_q;
            assign H[b] = h_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_repeater.sv
// Directed bench for button_repeater with NB=2, PRESCALE=4, DELAY_TICKS=3,
// REPEAT_TICKS=2, REPEAT_MASK=2'b01.
module tb_button_repeater;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] I     = 2'b00;
    logic [1:0] P;
    logic [1:0] H;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    button_repeater #(
        .NB           (2),
        .PRESCALE     (4),
        .DELAY_TICKS  (3),
        .REPEAT_TICKS (2),
        .REPEAT_MASK  (2'b01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .P     (P),
        .H     (H)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (edge %0d)", edge_n);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Press sampled on an edge with edge_n%4==1: ticks fall on edges +3,+7,+11,...
    // so the first repeat is at offset 11 and later ones every 8 cycles.
    function automatic logic rep_pulse(input int k);
        return (k == 0) || ((k >= 11) && (((k - 11) % 8) == 0));
    endfunction

    task automatic align();
        while ((edge_n % 4) != 0) step();
    endtask

    task automatic hold0(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk("hold0_p", P, {1'b0, rep_pulse(k)});
            chk("hold0_h", H, 2'b01);
        end
    endtask

    initial begin
        // Test 1: reset with both buttons held
        rst_n = 1'b0;
        I     = 2'b11;
        repeat (3) step();
        chk("rst_p", P, 2'b00);
        chk("rst_h", H, 2'b00);
        rst_n  = 1'b1;
        edge_n = 0;
        step();
        chk("rst_rel_p", P, 2'b11);
        chk("rst_rel_h", H, 2'b11);
        step();
        chk("rst_rel_p2", P, 2'b00);
        chk("rst_rel_h2", H, 2'b11);
        I = 2'b00;
        step();
        chk("rst_rel_off_p", P, 2'b00);
        chk("rst_rel_off_h", H, 2'b00);

        // Test 2: tap on button 0
        I = 2'b01;
        step();
        chk("tap_p", P, 2'b01);
        chk("tap_h", H, 2'b01);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tap_hold_p", P, 2'b00);
            chk("tap_hold_h", H, 2'b01);
        end
        I = 2'b00;
        step();
        chk("tap_rel_p", P, 2'b00);
        chk("tap_rel_h", H, 2'b00);
        step();
        chk("tap_after_p", P, 2'b00);

        // Test 3: hold repeating button
        align();
        I = 2'b01;
        hold0(40);
        I = 2'b00;
        step();
        chk("hold0_rel_p", P, 2'b00);
        chk("hold0_rel_h", H, 2'b00);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("hold0_quiet_p", P, 2'b00);
        end

        // Test 4: hold unmasked button
        I = 2'b10;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("hold1_p", P, (k == 0) ? 2'b10 : 2'b00);
            chk("hold1_h", H, 2'b10);
        end
        I = 2'b00;
        step();
        chk("hold1_rel_p", P, 2'b00);
        chk("hold1_rel_h", H, 2'b00);

        // Test 5: release coincident with the tick that would give the 2nd repeat
        align();
        I = 2'b01;
        for (int k = 0; k < 19; k++) begin
            step();
            chk("coin_pre_p", P, {1'b0, rep_pulse(k)});
            chk("coin_pre_h", H, 2'b01);
        end
        I = 2'b00;
        step();
        chk("coin_rel_p", P, 2'b00);
        chk("coin_rel_h", H, 2'b00);
        I = 2'b01;
        step();
        chk("coin_repress_p", P, 2'b01);
        chk("coin_repress_h", H, 2'b01);

        // Test 6: async reset while in REPEAT (press above was on an edge with edge_n%4==1)
        for (int k = 1; k < 12; k++) begin
            step();
            chk("arst_pre_p", P, {1'b0, rep_pulse(k)});
            chk("arst_pre_h", H, 2'b01);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_async_p", P, 2'b00);
        chk("arst_async_h", H, 2'b00);
        repeat (2) step();
        chk("arst_hold_p", P, 2'b00);
        chk("arst_hold_h", H, 2'b00);
        rst_n  = 1'b1;
        edge_n = 0;
        hold0(40);
        I = 2'b00;
        step();
        chk("arst_rel_p", P, 2'b00);
        chk("arst_rel_h", H, 2'b00);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("arst_quiet_p", P, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
